// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: FSM states, datapath
// select codes, immediate-type codes for Sign_Extend and the supported opcodes.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_AUIPC    = 4'd13,
      S_ILLEGAL  = 4'd14
   } state_t;

   localparam logic [2:0] Ext_ImmI = 3'd0;
   localparam logic [2:0] Ext_ImmS = 3'd1;
   localparam logic [2:0] Ext_ImmB = 3'd2;
   localparam logic [2:0] Ext_ImmU = 3'd3;
   localparam logic [2:0] Ext_ImmJ = 3'd4;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // State that follows DECODE for a given opcode.
   function automatic state_t decode_next(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE: return S_MEMADR;
         OP_RTYPE:          return S_EXECR;
         OP_ITYPE:          return S_EXECI;
         OP_BRANCH:         return S_BRANCH;
         OP_JAL:            return S_JAL;
         OP_JALR:           return S_JALR;
         OP_LUI:            return S_LUI;
         OP_AUIPC:          return S_AUIPC;
         default:           return S_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM: Moore outputs from the state register, except
// FETCH ir/pc writes (mem_ready) and BRANCH pc_write (zero); stalls while mem_ready is low.
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [2:0] imm_src,
   output logic       illegal_instr,
   output logic [3:0] state_o
);

   state_t state_q, state_d;

   logic mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s, illegal_s;

   // funct7b5 is consumed by the ALU decoder in the datapath, not here.
   logic unused_funct7b5;
   assign unused_funct7b5 = funct7b5;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = S_FETCH;
      mem_req_s   = 1'b0;
      mem_write_s = 1'b0;
      ir_write_s  = 1'b0;
      pc_write_s  = 1'b0;
      reg_write_s = 1'b0;
      illegal_s   = 1'b0;
      adr_src     = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      alu_op      = ALUOP_ADD;
      imm_src     = Ext_ImmI;
      case (state_q)
         S_FETCH: begin
            mem_req_s  = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            ir_write_s = mem_ready;
            pc_write_s = mem_ready;
            state_d    = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = (opcode == OP_JAL) ? Ext_ImmJ : Ext_ImmB;
            state_d   = decode_next(opcode);
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_src   = (opcode == OP_STORE) ? Ext_ImmS : Ext_ImmI;
            state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req_s = 1'b1;
            adr_src   = 1'b1;
            state_d   = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            result_src  = RES_MEM;
            reg_write_s = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req_s   = 1'b1;
            mem_write_s = 1'b1;
            adr_src     = 1'b1;
            state_d     = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_s = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALUOP_SUB;
            // Only beq/bne are decoded; other branch funct3 values never redirect.
            pc_write_s = (funct3[2:1] == 2'b00) & (zero ^ funct3[0]);
         end
         S_JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_write_s = 1'b1;
            state_d    = S_ALUWB;
         end
         S_JALR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = S_JAL;
         end
         S_LUI: begin
            alu_src_a = SRCA_ZERO;
            alu_src_b = SRCB_IMM;
            imm_src   = Ext_ImmU;
            state_d   = S_ALUWB;
         end
         S_AUIPC: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = Ext_ImmU;
            state_d   = S_ALUWB;
         end
         S_ILLEGAL: begin
            illegal_s = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Strobes are held off combinationally for the whole time reset is asserted.
   assign mem_req       = mem_req_s   & ~rst;
   assign mem_write     = mem_write_s & ~rst;
   assign ir_write      = ir_write_s  & ~rst;
   assign pc_write      = pc_write_s  & ~rst;
   assign reg_write     = reg_write_s & ~rst;
   assign illegal_instr = illegal_s   & ~rst;
   assign state_o       = state_q;

endmodule
